add_issue_unit: RTL and testbench
=================================

ADD_ISSUE_UNIT -- requirements
Module: add_issue_unit

Interface
REQ-001 Parameters SHALL be data_width (default 16, operand/result width), tag_width (default 3, ROB destination tag width), num_entries (default 3, reservation-station entries served).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on rising edge.
- flush  in  1  reset; synchronous, active-high.
- rs_busy  in  num_entries  per-entry busy flag.
- rs_Vj_valid, rs_Vk_valid  in  num_entries each  per-entry operand-present flags.
- rs_Vj, rs_Vk  in  num_entries*data_width each  packed operands; entry i at bits [i*data_width +: data_width].
- rs_op  in  num_entries*4  packed lc3b_opcode per entry.
- rs_dest  in  num_entries*tag_width  packed destination tag per entry.
- rs_release  out  num_entries  one-hot pulse; drives the selected entry's ld_busy with busy_in=0.
- cdb_req  out  1  broadcast request to CDB arbiter.
- cdb_grant  in  1  arbiter grant.
- cdb_tag  out  tag_width  broadcast tag.
- cdb_data  out  data_width  broadcast result.
- unit_busy  out  1  high whenever FSM is not IDLE.

Function
REQ-003 Entry i SHALL be ready when rs_busy[i] & rs_Vj_valid[i] & rs_Vk_valid[i].
REQ-004 FSM SHALL have states IDLE, EXEC, BCAST; transitions IDLE->EXEC when any entry is ready, EXEC->BCAST unconditionally, BCAST->IDLE when cdb_grant=1, else stay in BCAST.
REQ-005 Selection SHALL be round-robin: search indices ptr, ptr+1, ... modulo num_entries; first ready index wins.
REQ-006 On issue of index i, ptr SHALL become (i+1) mod num_entries; ptr SHALL be unchanged in all other cycles.
REQ-007 In the IDLE cycle that issues entry i, the unit SHALL latch Vj, Vk, op, dest of entry i and assert rs_release[i] combinationally for that cycle only.
REQ-008 rs_release SHALL be all-zero in EXEC, BCAST, IDLE with no ready entry, and whenever flush=1.
REQ-009 In EXEC the unit SHALL compute and register the result: ADD (0001) Vj+Vk modulo 2^data_width; AND (0101) Vj&Vk; NOT (1001) ~Vj; any other opcode passes Vj unchanged.
REQ-010 In BCAST, cdb_req SHALL be 1, with cdb_tag and cdb_data holding the latched tag and result, stable until the grant cycle.
REQ-011 cdb_req SHALL be 0 in IDLE and EXEC; cdb_tag/cdb_data SHALL read 0 when cdb_req=0.
REQ-012 cdb_grant SHALL be ignored outside BCAST.
REQ-013 Latency: issue in cycle t; cdb_req=1 from cycle t+2; with grant in t+2, cdb_req=0 and state IDLE in t+3; next issue no earlier than t+3.
REQ-014 Entry readiness changes while not IDLE SHALL have no effect; a previously released entry is never reissued unless its rs_busy is set again.

Reset
REQ-015 While flush=1 at a rising edge, the FSM SHALL enter IDLE, ptr=0, latched operands/op/tag/result=0, and no issue SHALL occur that cycle.
REQ-016 After flush: cdb_req=0, cdb_tag=0, cdb_data=0, unit_busy=0, rs_release=0.
REQ-017 Flush during EXEC or BCAST SHALL discard the in-flight result; no broadcast of it SHALL ever occur.

Verification
REQ-018 Entry 1 ready, ADD Vj=0x7FFF Vk=0x0001 dest=5 -> rs_release=010 in issue cycle; cdb_req=1, tag=5, data=0x8000 two cycles later.
REQ-019 ADD Vj=0xFFFF Vk=0x0002 -> data=0x0001; NOT Vj=0x00F0 -> data=0xFF0F; AND 0x0F0F&0x00FF -> data=0x000F.
REQ-020 All three entries ready, ptr=0, grant every BCAST -> issue order 0,1,2,0 with release pulses 001,010,100,001.
REQ-021 cdb_grant held 0 for 5 cycles in BCAST -> cdb_req, tag, data stable 5 cycles; grant on 6th -> IDLE next cycle, no new release while waiting.
REQ-022 flush asserted in BCAST with tag=3 pending -> next cycle cdb_req=0, unit_busy=0, ptr=0; tag 3 never broadcast.
REQ-023 Entry ready with only rs_Vj_valid=1 -> no release, state stays IDLE until rs_Vk_valid rises, then issue that cycle.

Source files
------------

// File: rtl/add_issue_unit.sv
// Adder-class issue unit: picks a ready reservation-station entry round-robin,
// executes ADD/AND/NOT in one cycle, and holds the result on the CDB until granted.
module add_issue_unit #(
  parameter int data_width  = 16,
  parameter int tag_width   = 3,
  parameter int num_entries = 3
) (
  input  logic                            clk,
  input  logic                            flush,
  input  logic [num_entries-1:0]          rs_busy,
  input  logic [num_entries-1:0]          rs_Vj_valid,
  input  logic [num_entries-1:0]          rs_Vk_valid,
  input  logic [num_entries*data_width-1:0] rs_Vj,
  input  logic [num_entries*data_width-1:0] rs_Vk,
  input  logic [num_entries*4-1:0]        rs_op,
  input  logic [num_entries*tag_width-1:0] rs_dest,
  output logic [num_entries-1:0]          rs_release,
  output logic                            cdb_req,
  input  logic                            cdb_grant,
  output logic [tag_width-1:0]            cdb_tag,
  output logic [data_width-1:0]           cdb_data,
  output logic                            unit_busy
);

  localparam int ptr_width = (num_entries > 1) ? $clog2(num_entries) : 1;

  localparam logic [3:0] op_add = 4'b0001;
  localparam logic [3:0] op_and = 4'b0101;
  localparam logic [3:0] op_not = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    BCAST
  } state_t;

  state_t state, next_state;

  logic [ptr_width-1:0]   ptr;
  logic [ptr_width-1:0]   sel;
  logic [num_entries-1:0] ready;
  logic                   any_ready;
  logic                   issue;
  int                     rr_idx;

  logic [data_width-1:0]  sel_vj, sel_vk;
  logic [3:0]             sel_op;
  logic [tag_width-1:0]   sel_dest;

  logic [data_width-1:0]  vj_q, vk_q, result_q, alu_result;
  logic [3:0]             op_q;
  logic [tag_width-1:0]   dest_q;

  assign ready = rs_busy & rs_Vj_valid & rs_Vk_valid;

  // Round-robin search starting at ptr; the first ready index in wrap order wins.
  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    rr_idx    = 0;
    for (int k = 0; k < num_entries; k++) begin
      rr_idx = int'(ptr) + k;
      if (rr_idx >= num_entries) rr_idx = rr_idx - num_entries;
      for (int i = 0; i < num_entries; i++) begin
        if (!any_ready && rr_idx == i && ready[i]) begin
          any_ready = 1'b1;
          sel       = ptr_width'(i);
        end
      end
    end
  end

  assign issue = (state == IDLE) && any_ready && !flush;

  always_comb begin
    sel_vj   = '0;
    sel_vk   = '0;
    sel_op   = '0;
    sel_dest = '0;
    for (int i = 0; i < num_entries; i++) begin
      if (int'(sel) == i) begin
        sel_vj   = rs_Vj[i*data_width +: data_width];
        sel_vk   = rs_Vk[i*data_width +: data_width];
        sel_op   = rs_op[i*4 +: 4];
        sel_dest = rs_dest[i*tag_width +: tag_width];
      end
    end
  end

  always_comb begin
    alu_result = vj_q;
    case (op_q)
      op_add:  alu_result = vj_q + vk_q;
      op_and:  alu_result = vj_q & vk_q;
      op_not:  alu_result = ~vj_q;
      default: alu_result = vj_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_ready) next_state = EXEC;
      EXEC:    next_state = BCAST;
      BCAST:   if (cdb_grant) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cdb_req is masked by flush so a grant in the flush cycle cannot complete a discarded broadcast.
  always_comb begin
    rs_release = '0;
    for (int i = 0; i < num_entries; i++) begin
      rs_release[i] = issue && (int'(sel) == i);
    end
    cdb_req   = (state == BCAST) && !flush;
    cdb_tag   = cdb_req ? dest_q : '0;
    cdb_data  = cdb_req ? result_q : '0;
    unit_busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      ptr      <= '0;
      vj_q     <= '0;
      vk_q     <= '0;
      op_q     <= '0;
      dest_q   <= '0;
      result_q <= '0;
    end else begin
      if (issue) begin
        vj_q   <= sel_vj;
        vk_q   <= sel_vk;
        op_q   <= sel_op;
        dest_q <= sel_dest;
        if (int'(sel) == num_entries - 1) begin
          ptr <= '0;
        end else begin
          ptr <= sel + ptr_width'(1);
        end
      end
      if (state == EXEC) begin
        result_q <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_add_issue_unit.sv
// Directed bench for add_issue_unit: each task drives one scenario and checks
// release pulses, FSM timing and CDB outputs against hand-computed values.
module tb_add_issue_unit;

  localparam int DW = 16;
  localparam int TW = 3;
  localparam int NE = 3;

  logic              clk = 1'b0;
  logic              flush;
  logic [NE-1:0]     rs_busy, rs_Vj_valid, rs_Vk_valid;
  logic [NE*DW-1:0]  rs_Vj, rs_Vk;
  logic [NE*4-1:0]   rs_op;
  logic [NE*TW-1:0]  rs_dest;
  logic [NE-1:0]     rs_release;
  logic              cdb_req, cdb_grant, unit_busy;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;

  int vectors     = 0;
  int miscompares = 0;

  add_issue_unit #(.data_width(DW), .tag_width(TW), .num_entries(NE)) dut (
    .clk(clk), .flush(flush),
    .rs_busy(rs_busy), .rs_Vj_valid(rs_Vj_valid), .rs_Vk_valid(rs_Vk_valid),
    .rs_Vj(rs_Vj), .rs_Vk(rs_Vk), .rs_op(rs_op), .rs_dest(rs_dest),
    .rs_release(rs_release), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .unit_busy(unit_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int i, input logic busy, input logic vjv, input logic vkv,
                           input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                           input logic [3:0] op, input logic [TW-1:0] dest);
    rs_busy[i]         = busy;
    rs_Vj_valid[i]     = vjv;
    rs_Vk_valid[i]     = vkv;
    rs_Vj[i*DW +: DW]  = vj;
    rs_Vk[i*DW +: DW]  = vk;
    rs_op[i*4 +: 4]    = op;
    rs_dest[i*TW +: TW] = dest;
  endtask

  task automatic clear_all();
    rs_busy = '0; rs_Vj_valid = '0; rs_Vk_valid = '0;
    rs_Vj = '0; rs_Vk = '0; rs_op = '0; rs_dest = '0;
  endtask

  // Called in the IDLE cycle where the entry is already ready; follows it through EXEC and BCAST.
  task automatic issue_and_broadcast(input string name, input int entry, input logic [NE-1:0] exp_rel,
                                     input logic [TW-1:0] exp_tag, input logic [DW-1:0] exp_data,
                                     input bit clear_entry);
    #1;
    vectors++;
    if (rs_release !== exp_rel) begin
      miscompares++;
      $display("[TB] FAIL %s issue release: got %b expected %b", name, rs_release, exp_rel);
    end
    step();
    if (clear_entry) rs_busy[entry] = 1'b0;
    #1;
    vectors++;
    if (rs_release !== 3'b000 || cdb_req !== 1'b0 || unit_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s exec: got rel=%b req=%b busy=%b expected rel=000 req=0 busy=1",
               name, rs_release, cdb_req, unit_busy);
    end
    step();
    vectors++;
    if (cdb_req !== 1'b1 || cdb_tag !== exp_tag || cdb_data !== exp_data || rs_release !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL %s bcast: got req=%b tag=%0d data=%h rel=%b expected req=1 tag=%0d data=%h rel=000",
               name, cdb_req, cdb_tag, cdb_data, rs_release, exp_tag, exp_data);
    end
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    vectors++;
    if (cdb_req !== 1'b0 || unit_busy !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s after grant: got req=%b busy=%b tag=%0d data=%h expected 0 0 0 0000",
               name, cdb_req, unit_busy, cdb_tag, cdb_data);
    end
  endtask

  task automatic test_reset();
    flush = 1'b1; cdb_grant = 1'b0;
    clear_all();
    step();
    set_entry(0, 1, 1, 1, 16'h1111, 16'h2222, 4'b0001, 3'd1);
    #1;
    vectors++;
    if (rs_release !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset release during flush: got %b expected 000", rs_release);
    end
    step();
    vectors++;
    if (unit_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset no issue under flush: got busy=%b expected 0", unit_busy);
    end
    clear_all();
    flush = 1'b0;
    #1;
    vectors++;
    if (cdb_req !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 || unit_busy !== 1'b0 || rs_release !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset outputs: got req=%b tag=%0d data=%h busy=%b rel=%b expected all zero",
               cdb_req, cdb_tag, cdb_data, unit_busy, rs_release);
    end
    step();
  endtask

  task automatic test_add_overflow();
    set_entry(1, 1, 1, 1, 16'h7FFF, 16'h0001, 4'b0001, 3'd5);
    issue_and_broadcast("add_overflow", 1, 3'b010, 3'd5, 16'h8000, 1);
  endtask

  task automatic test_alu_ops();
    set_entry(2, 1, 1, 1, 16'hFFFF, 16'h0002, 4'b0001, 3'd2);
    issue_and_broadcast("add_wrap", 2, 3'b100, 3'd2, 16'h0001, 1);
    set_entry(0, 1, 1, 1, 16'h00F0, 16'hAAAA, 4'b1001, 3'd6);
    issue_and_broadcast("not", 0, 3'b001, 3'd6, 16'hFF0F, 1);
    set_entry(1, 1, 1, 1, 16'h0F0F, 16'h00FF, 4'b0101, 3'd7);
    issue_and_broadcast("and", 1, 3'b010, 3'd7, 16'h000F, 1);
    set_entry(2, 1, 1, 1, 16'h1234, 16'h5555, 4'b0000, 3'd0);
    issue_and_broadcast("pass_vj", 2, 3'b100, 3'd0, 16'h1234, 1);
  endtask

  task automatic test_round_robin();
    logic [NE-1:0] exp_rel  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [TW-1:0] exp_tag  [4] = '{3'd4, 3'd5, 3'd6, 3'd4};
    logic [DW-1:0] exp_data [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0101};
    set_entry(0, 1, 1, 1, 16'h0100, 16'h0001, 4'b0001, 3'd4);
    set_entry(1, 1, 1, 1, 16'h0200, 16'h0002, 4'b0001, 3'd5);
    set_entry(2, 1, 1, 1, 16'h0300, 16'h0003, 4'b0001, 3'd6);
    for (int n = 0; n < 4; n++) begin
      issue_and_broadcast("round_robin", 0, exp_rel[n], exp_tag[n], exp_data[n], 0);
    end
    clear_all();
    step();
  endtask

  task automatic test_grant_stall();
    set_entry(1, 1, 1, 1, 16'h4000, 16'h0321, 4'b0001, 3'd3);
    #1;
    vectors++;
    if (rs_release !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL stall issue release: got %b expected 010", rs_release);
    end
    step();
    rs_busy[1] = 1'b0;
    step();
    set_entry(2, 1, 1, 1, 16'h0005, 16'h0006, 4'b0001, 3'd1);
    for (int n = 0; n < 5; n++) begin
      #1;
      vectors++;
      if (cdb_req !== 1'b1 || cdb_tag !== 3'd3 || cdb_data !== 16'h4321 || rs_release !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL stall hold cycle %0d: got req=%b tag=%0d data=%h rel=%b expected 1 3 4321 000",
                 n, cdb_req, cdb_tag, cdb_data, rs_release);
      end
      step();
    end
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    #1;
    vectors++;
    if (unit_busy !== 1'b0 || cdb_req !== 1'b0 || rs_release !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL stall release after grant: got busy=%b req=%b rel=%b expected 0 0 100",
               unit_busy, cdb_req, rs_release);
    end
    clear_all();
    step();
  endtask

  task automatic test_flush_bcast();
    set_entry(1, 1, 1, 1, 16'h0011, 16'h0022, 4'b0001, 3'd3);
    step();
    rs_busy[1] = 1'b0;
    step();
    vectors++;
    if (cdb_req !== 1'b1 || cdb_tag !== 3'd3) begin
      miscompares++;
      $display("[TB] FAIL flush_bcast pending: got req=%b tag=%0d expected 1 3", cdb_req, cdb_tag);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    cdb_grant = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      vectors++;
      if (cdb_req !== 1'b0 || unit_busy !== 1'b0 || cdb_tag !== '0) begin
        miscompares++;
        $display("[TB] FAIL flush_bcast discarded cycle %0d: got req=%b busy=%b tag=%0d expected 0 0 0",
                 n, cdb_req, unit_busy, cdb_tag);
      end
      step();
    end
    cdb_grant = 1'b0;
    set_entry(0, 1, 1, 1, 16'h0009, 16'h0001, 4'b0001, 3'd2);
    set_entry(2, 1, 1, 1, 16'h0007, 16'h0001, 4'b0001, 3'd4);
    issue_and_broadcast("flush_ptr_reset", 0, 3'b001, 3'd2, 16'h000A, 1);
    clear_all();
    step();
  endtask

  task automatic test_flush_exec();
    set_entry(0, 1, 1, 1, 16'h0100, 16'h0200, 4'b0001, 3'd7);
    step();
    rs_busy[0] = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    cdb_grant = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      vectors++;
      if (cdb_req !== 1'b0 || unit_busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_exec discarded cycle %0d: got req=%b busy=%b expected 0 0",
                 n, cdb_req, unit_busy);
      end
      step();
    end
    cdb_grant = 1'b0;
  endtask

  task automatic test_partial_operands();
    set_entry(0, 1, 1, 0, 16'h0003, 16'h0004, 4'b0001, 3'd1);
    for (int n = 0; n < 3; n++) begin
      #1;
      vectors++;
      if (rs_release !== 3'b000 || unit_busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL partial wait cycle %0d: got rel=%b busy=%b expected 000 0",
                 n, rs_release, unit_busy);
      end
      step();
    end
    rs_Vk_valid[0] = 1'b1;
    issue_and_broadcast("partial_then_ready", 0, 3'b001, 3'd1, 16'h0007, 1);
    clear_all();
    step();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_alu_ops();
    test_round_robin();
    test_grant_stall();
    test_flush_bcast();
    test_flush_exec();
    test_partial_operands();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
